// File: rtl/rng_card_dealer.sv
// Xorshift card dealer: steps the generator until a draw maps to an unbiased,
// optionally not-yet-dealt card index, then holds it for a req/valid/ack consumer.
module rng_card_dealer #(
  parameter int                 WIDTH      = 32,
  parameter int                 SHIFT_A    = 13,
  parameter int                 SHIFT_B    = 17,
  parameter int                 SHIFT_C    = 5,
  parameter logic [WIDTH-1:0]   SEED       = WIDTH'(32'h2545F491),
  parameter int                 RANGE      = 52,
  parameter bit                 NO_REPLACE = 1'b1,
  localparam int                CW         = $clog2(RANGE + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             seed_we,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             deck_clear,
  input  logic             req,
  input  logic             card_ack,
  output logic             busy,
  output logic             card_valid,
  output logic [CW-1:0]    card,
  output logic [WIDTH-1:0] raw,
  output logic [CW-1:0]    dealt_count,
  output logic             deck_empty
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GEN   = 2'd1,
    S_VALID = 2'd2
  } state_e;

  // Largest multiple of RANGE that fits in WIDTH bits; draws at or above it are biased.
  localparam logic [WIDTH:0] POW2  = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] LIMIT = (POW2 / (WIDTH+1)'(RANGE)) * (WIDTH+1)'(RANGE);

  state_e             fsm_q;
  logic [WIDTH-1:0]   s_q;
  logic [RANGE-1:0]   bitmap_q;
  logic [CW-1:0]      card_q;
  logic               valid_q;
  logic               busy_q;
  logic [CW-1:0]      count_q;
  logic               empty_q;

  logic [WIDTH-1:0]   t1, t2, s_d;
  logic [CW-1:0]      idx;
  logic [CW-1:0]      card_d;
  logic [CW-1:0]      count_d;
  logic [WIDTH-1:0]   seed_d;
  logic [RANGE-1:0]   hit_vec;
  logic [RANGE-1:0]   set_vec;
  logic               below_limit;
  logic               taken;
  logic               accept;

  assign t1  = s_q ^ (s_q << SHIFT_A);
  assign t2  = t1 ^ (t1 >> SHIFT_B);
  assign s_d = t2 ^ (t2 << SHIFT_C);

  assign below_limit = {1'b0, s_d} < LIMIT;
  assign idx         = CW'(s_d % WIDTH'(RANGE));
  assign card_d      = idx + 1'b1;
  assign count_d     = count_q + 1'b1;
  assign seed_d      = (seed_in == '0) ? SEED : seed_in;

  // One-hot decode of the candidate index (lookup) and the acked card (mark).
  for (genvar gi = 0; gi < RANGE; gi++) begin : g_bitmap
    assign hit_vec[gi] = bitmap_q[gi] && (idx == CW'(gi));
    assign set_vec[gi] = (card_q == CW'(gi + 1));
  end

  assign taken  = |hit_vec;
  assign accept = below_limit && !(NO_REPLACE && taken);

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q    <= S_IDLE;
      s_q      <= SEED;
      bitmap_q <= '0;
      card_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      count_q  <= '0;
      empty_q  <= 1'b0;
    end else if (seed_w_e_abort(seed_we)) begin
      s_q     <= seed_d;
      fsm_q   <= S_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (deck_clear) begin
        bitmap_q <= '0;
        count_q  <= '0;
        empty_q  <= 1'b0;
      end
      case (fsm_q)
        S_IDLE: begin
          if (req && !empty_q) begin
            fsm_q  <= S_GEN;
            busy_q <= 1'b1;
          end
        end
        S_GEN: begin
          s_q <= s_d;
          if (accept) begin
            card_q  <= card_d;
            fsm_q   <= S_VALID;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        S_VALID: begin
          if (card_ack) begin
            fsm_q   <= S_IDLE;
            valid_q <= 1'b0;
            // A simultaneous reshuffle overrides the marking of this card.
            if (!deck_clear) begin
              if (NO_REPLACE) begin
                bitmap_q <= bitmap_q | set_vec;
              end
              count_q <= count_d;
              empty_q <= NO_REPLACE && (count_d == CW'(RANGE));
            end
          end
        end
        default: begin
          fsm_q   <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  function automatic logic seed_w_e_abort(input logic we);
    return we;
  endfunction

  assign busy        = busy_q;
  assign card_valid  = valid_q;
  assign card        = card_q;
  assign raw         = s_q;
  assign dealt_count = count_q;
  assign deck_empty  = empty_q;

endmodule

// File: tb/tb_rng_card_dealer.sv
// Randomized bench for rng_card_dealer: a 32-bit no-replacement dealer and a
// 64-bit independent-draw dealer, both checked against a behavioural model.
module tb_rng_card_dealer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit, defaults
  logic        r32, sw32, dc32, rq32, ak32;
  logic [31:0] si32, raw32;
  logic        b32, v32, e32;
  logic [5:0]  c32, cnt32;

  // 64-bit, NO_REPLACE=0
  logic        r64, sw64, dc64, rq64, ak64;
  logic [63:0] si64, raw64;
  logic        b64, v64, e64;
  logic [5:0]  c64, cnt64;

  rng_card_dealer dut32 (
    .clock(clk), .reset(r32), .seed_we(sw32), .seed_in(si32), .deck_clear(dc32),
    .req(rq32), .card_ack(ak32), .busy(b32), .card_valid(v32), .card(c32),
    .raw(raw32), .dealt_count(cnt32), .deck_empty(e32)
  );

  rng_card_dealer #(
    .WIDTH(64), .SHIFT_A(13), .SHIFT_B(7), .SHIFT_C(17),
    .SEED(64'h2545F491), .RANGE(52), .NO_REPLACE(1'b0)
  ) dut64 (
    .clock(clk), .reset(r64), .seed_we(sw64), .seed_in(si64), .deck_clear(dc64),
    .req(rq64), .card_ack(ak64), .busy(b64), .card_valid(v64), .card(c64),
    .raw(raw64), .dealt_count(cnt64), .deck_empty(e64)
  );

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [63:0] SEED32 = 64'h2545F491;
  localparam logic [63:0] LIM32  = ((64'd1 << 32) / 64'd52) * 64'd52;
  // 52 does not divide 2^64, so floor((2^64-1)/52) == floor(2^64/52).
  localparam logic [63:0] LIM64  = (64'hFFFF_FFFF_FFFF_FFFF / 64'd52) * 64'd52;

  logic [63:0] m32_s, m64_s;
  bit          dealt32 [1:52];
  int          m32_cnt, m64_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] step(input logic [63:0] s, input bit w64);
    logic [31:0] y;
    logic [63:0] x;
    if (!w64) begin
      y = s[31:0];
      y = y ^ (y << 13);
      y = y ^ (y >> 17);
      y = y ^ (y << 5);
      return {32'd0, y};
    end
    x = s;
    x = x ^ (x << 13);
    x = x ^ (x >> 7);
    x = x ^ (x << 17);
    return x;
  endfunction

  // Seed whose 32-bit successor is the given value.
  function automatic logic [31:0] unstep32(input logic [31:0] y);
    logic [31:0] a, b, c;
    a = y;
    for (int i = 0; i < 32; i++) a = y ^ (a << 5);
    b = a ^ (a >> 17);
    c = b;
    for (int i = 0; i < 32; i++) c = b ^ (c << 13);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model32();
    for (int k = 1; k <= 52; k++) dealt32[k] = 1'b0;
    m32_cnt = 0;
  endtask

  task automatic check_idle32(input string tag);
    chk({tag, "_busy"}, b32, 0);
    chk({tag, "_valid"}, v32, 0);
    chk({tag, "_raw"}, raw32, m32_s);
    chk({tag, "_count"}, cnt32, m32_cnt);
    chk({tag, "_empty"}, e32, (m32_cnt == 52));
  endtask

  // One request on the 32-bit dealer; leaves DUT in VALID when do_ack=0.
  task automatic draw32(input int ack_delay, input bit do_ack);
    logic [63:0] s;
    int n, c, cyc;
    s = m32_s;
    n = 0;
    do begin
      s = step(s, 1'b0);
      n++;
      c = int'(s % 64'd52) + 1;
    end while (!((s < LIM32) && !dealt32[c]) && n < 100000);
    rq32 = 1'b1;
    tick();
    rq32 = 1'b0;
    cyc = 1;
    chk("busy_after_req32", b32, 1);
    while (!v32 && cyc < 5000) begin
      tick();
      cyc++;
    end
    chk("latency32", cyc, n + 1);
    chk("card32", c32, c);
    chk("raw32", raw32, s);
    chk("busy_in_valid32", b32, 0);
    chk("fresh_card32", dealt32[c32 == 0 ? 1 : (c32 > 52 ? 52 : c32)], 0);
    m32_s = s;
    if (do_ack) begin
      repeat (ack_delay) tick();
      chk("card_stable32", c32, c);
      ak32 = 1'b1;
      tick();
      ak32 = 1'b0;
      dealt32[c] = 1'b1;
      m32_cnt++;
      chk("valid_drop32", v32, 0);
      chk("count32", cnt32, m32_cnt);
      chk("empty32", e32, (m32_cnt == 52));
      $display("draw32 card=%0d raw=%0d latency=%0d count=%0d", c32, raw32, cyc, cnt32);
    end
  endtask

  task automatic draw64();
    logic [63:0] s;
    int n, c, cyc;
    s = m64_s;
    n = 0;
    do begin
      s = step(s, 1'b1);
      n++;
      c = int'(s % 64'd52) + 1;
    end while (!(s < LIM64) && n < 100000);
    rq64 = 1'b1;
    tick();
    rq64 = 1'b0;
    cyc = 1;
    while (!v64 && cyc < 5000) begin
      tick();
      cyc++;
    end
    chk("latency64", cyc, n + 1);
    chk("card64", c64, c);
    chk("range64", (c64 >= 1 && c64 <= 52), 1);
    chk("raw64", raw64, s);
    m64_s = s;
    ak64 = 1'b1;
    tick();
    ak64 = 1'b0;
    m64_cnt++;
    chk("count64", cnt64, m64_cnt % 64);
    chk("empty64", e64, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] sd;
    logic [63:0] sd64;
    int          saved;

    r32 = 1'b1; sw32 = 1'b0; si32 = '0; dc32 = 1'b0; rq32 = 1'b0; ak32 = 1'b0;
    r64 = 1'b1; sw64 = 1'b0; si64 = '0; dc64 = 1'b0; rq64 = 1'b0; ak64 = 1'b0;
    tick();
    tick();
    r32 = 1'b0;
    r64 = 1'b0;
    m32_s = SEED32;
    clear_model32();
    m64_s = 64'h2545F491;
    m64_cnt = 0;
    check_idle32("reset32");
    chk("reset32_card", c32, 0);
    chk("reset64_raw", raw64, 64'h2545F491);
    chk("reset64_valid", v64, 0);
    $display("reset checked");

    // Seed 1: first draw is 270369 -> card 22.
    sw32 = 1'b1; si32 = 32'd1;
    tick();
    sw32 = 1'b0;
    chk("seed_load32", raw32, 1);
    m32_s = 64'd1;
    draw32(0, 1'b1);
    chk("first_raw32", raw32, 270369);
    chk("first_count32", cnt32, 1);
    draw32(1, 1'b1);

    // Bias rejection: seed whose successor lies above LIMIT.
    sd = unstep32(32'hFFFF_FFF0);
    sw32 = 1'b1; si32 = sd;
    tick();
    sw32 = 1'b0;
    m32_s = {32'd0, sd};
    chk("rej_seed32", raw32, sd);
    draw32(0, 1'b1);

    // Random seeds and ack delays.
    for (int i = 0; i < 4; i++) begin
      sd = $urandom | 32'd1;
      sw32 = 1'b1; si32 = sd;
      tick();
      sw32 = 1'b0;
      m32_s = {32'd0, sd};
      draw32(int'($urandom_range(0, 3)), 1'b1);
    end

    // Full deck without replacement.
    dc32 = 1'b1;
    tick();
    dc32 = 1'b0;
    clear_model32();
    check_idle32("clear32");
    for (int i = 0; i < 52; i++) draw32(int'($urandom_range(0, 2)), 1'b1);
    chk("full_count32", cnt32, 52);
    chk("full_empty32", e32, 1);
    rq32 = 1'b1;
    tick();
    rq32 = 1'b0;
    chk("empty_req_busy32", b32, 0);
    tick();
    chk("empty_req_busy32_b", b32, 0);
    chk("empty_req_valid32", v32, 0);
    dc32 = 1'b1;
    tick();
    dc32 = 1'b0;
    clear_model32();
    check_idle32("reshuffle32");
    draw32(0, 1'b1);

    // seed_we during GEN.
    saved = m32_cnt;
    rq32 = 1'b1;
    tick();
    rq32 = 1'b0;
    chk("midgen_busy32", b32, 1);
    sd = $urandom | 32'd1;
    sw32 = 1'b1; si32 = sd;
    tick();
    sw32 = 1'b0;
    m32_s = {32'd0, sd};
    check_idle32("midgen32");
    chk("midgen_count32", cnt32, saved);
    tick();
    chk("midgen_stay_idle32", b32, 0);
    chk("midgen_raw_frozen32", raw32, sd);

    // seed_we during VALID with seed_in=0 loads SEED.
    draw32(0, 1'b0);
    sw32 = 1'b1; si32 = 32'd0;
    tick();
    sw32 = 1'b0;
    m32_s = SEED32;
    check_idle32("midvalid32");
    draw32(0, 1'b1);

    // deck_clear together with card_ack.
    draw32(0, 1'b0);
    dc32 = 1'b1; ak32 = 1'b1;
    tick();
    dc32 = 1'b0; ak32 = 1'b0;
    clear_model32();
    check_idle32("clear_ack32");
    draw32(0, 1'b1);
    draw32(1, 1'b1);

    // Reset during GEN.
    rq32 = 1'b1;
    tick();
    rq32 = 1'b0;
    chk("rst_gen_busy32", b32, 1);
    r32 = 1'b1;
    tick();
    r32 = 1'b0;
    m32_s = SEED32;
    clear_model32();
    check_idle32("rst_gen32");
    chk("rst_gen_card32", c32, 0);
    draw32(0, 1'b1);

    // 64-bit independent draws.
    for (int i = 0; i < 1000; i++) begin
      if (i % 100 == 0) begin
        sd64 = {$urandom, $urandom} | 64'd1;
        sw64 = 1'b1; si64 = sd64;
        tick();
        sw64 = 1'b0;
        m64_s = sd64;
        chk("seed_load64", raw64, sd64);
      end
      draw64();
      if (i % 100 == 99) $display("draw64 #%0d card=%0d raw=%0h", i + 1, c64, raw64);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
